event_count_ctrl: RTL and testbench
===================================

EVENT_COUNT_CTRL -- requirements
Module: event_count_ctrl

Interface
REQ-001 Parameter: WIDTH, 4, width of the event counter and terminal-count value (WIDTH >= 2).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: start  input  1  begin a counting run; honoured only in IDLE.
REQ-005 Port: abort  input  1  terminate the current run; honoured in RUN and DONE.
REQ-006 Port: x  input  1  qualifying event, sampled each rising edge in RUN.
REQ-007 Port: tc  input  WIDTH  terminal count, captured at start.
REQ-008 Port: mode  input  2  bit0 = consecutive (1) / cumulative (0); bit1 = auto-restart (1) / one-shot (0); captured at start.
REQ-009 Port: count  output  WIDTH  current event count, registered.
REQ-010 Port: done  output  1  one-cycle completion pulse, registered.
REQ-011 Port: busy  output  1  high when state is not IDLE.
REQ-012 Port: state  output  2  IDLE=0, RUN=1, DONE=2; 3 unreachable.

Function
REQ-013 FSM states SHALL be IDLE, RUN and DONE; done SHALL be high exactly when state = DONE.
REQ-014 In IDLE with start=1: tc and mode are captured into tc_q and mode_q, count is cleared to 0, and the next state is RUN; if tc = 0, the next state is DONE instead.
REQ-015 In IDLE with start=0: state, count, tc_q and mode_q are held.
REQ-016 In RUN with x=1: count increments by 1; if count = tc_q-1, the next state is DONE.
REQ-017 In RUN with x=0: count is held if mode_q[0]=0, or cleared to 0 if mode_q[0]=1.
REQ-018 DONE lasts exactly one cycle and x is ignored; then, if mode_q[1]=0, the next state is IDLE with count held at tc_q; if mode_q[1]=1, the next state is RUN with count cleared to 0.
REQ-019 Changes on tc and mode after capture have no effect until the next accepted start.
REQ-020 start outside IDLE is ignored.
REQ-021 abort in RUN or DONE forces IDLE on the next edge with count held; it has priority over an increment, reaching tc_q and auto-restart; no done pulse follows.
REQ-022 count never exceeds tc_q; no wrap-around is reachable.
REQ-023 Latency: from start sampled to first possible increment is 1 cycle; from the final x to done is 1 edge (done is concurrent with the count = tc_q update).

Reset
REQ-024 rst_n=0 immediately forces state=IDLE, count=0, done=0, busy=0, tc_q=0 and mode_q=0, regardless of the clock, including mid-run.
REQ-025 After rst_n deasserts, the first start is accepted on the first rising edge at which it is sampled high.

Structure
REQ-026 The shared package event_count_pkg SHALL hold the state type/encoding (IDLE, RUN, DONE) and the mode bit indices (MODE_CONSEC=0, MODE_AUTO=1).
REQ-027 The counter is the single sub-module sat_counter (parameter WIDTH; ports clk, rst_n, sync clear, enable, q).
REQ-028 The FSM next-state logic and the clear/enable generation reside in event_count_ctrl.

Verification (WIDTH=4)
REQ-029 Reset mid-run: count=5 in RUN, rst_n low -> count=0, state=IDLE and done=0 before the next edge.
REQ-030 Cumulative one-shot: tc=3, mode=00, start, then x=1,0,1,1 -> count 1,1,2,3; done high for 1 cycle with count=3; then IDLE with count held at 3.
REQ-031 Consecutive: tc=3, mode=01, x=1,1,0,1,1,1 -> count 1,2,0,1,2,3; single done pulse.
REQ-032 Auto-restart: tc=2, mode=10, x held at 1 -> done every 3 cycles (count 1,2,0 repeating) until abort, after which state=IDLE and done stays low.
REQ-033 tc=0: start -> DONE on the next edge, done for 1 cycle, count=0, then IDLE.
REQ-034 Abort priority: tc=3, count=2, x=1 and abort=1 on the same edge -> IDLE, count=2, no done pulse.

Source files
------------

// File: rtl/event_count_pkg.sv
// Shared definitions for the event counting controller: FSM state encoding
// and the bit positions of the captured mode word.
package event_count_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Mode bit 0: 1 = events must be consecutive, 0 = cumulative.
    localparam int MODE_CONSEC = 0;
    // Mode bit 1: 1 = restart a new run after completion, 0 = one-shot.
    localparam int MODE_AUTO   = 1;

endpackage : event_count_pkg

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear and enable. It stops at all-ones
// instead of wrapping, so a stray enable can never roll the count over.
module sat_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             at_max;

    assign at_max = (q_q == {WIDTH{1'b1}});

    // Next count: clear wins over enable; enable saturates at all-ones.
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (en && !at_max) begin
            q_d = q_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    // Count register with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule : sat_counter

// File: rtl/event_count_ctrl.sv
// Event counting controller. A run is launched from IDLE with a terminal
// count and mode word captured at start; qualifying events advance the
// counter until it reaches the terminal count, which raises a one-cycle
// done pulse. Runs may be one-shot or auto-restarting, and events may be
// counted cumulatively or required to be consecutive. abort returns to IDLE
// from any active state without a done pulse.
module event_count_ctrl
    import event_count_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             x,
    input  logic [WIDTH-1:0] tc,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] count,
    output logic             done,
    output logic             busy,
    output logic [1:0]       state
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] tc_q, tc_d;
    logic [1:0]       mode_q, mode_d;
    logic             done_q;

    logic             cnt_clr;
    logic             cnt_en;
    logic [WIDTH-1:0] count_q;

    // One bit wider so count+1 cannot overflow when comparing with tc_q.
    logic [WIDTH:0]   count_inc;
    logic             reach_tc;
    logic             below_tc;

    assign count_inc = {1'b0, count_q} + {{WIDTH{1'b0}}, 1'b1};
    // The event being sampled now is the one that completes the run. Using
    // >= also makes a run with tc_q = 0 (possible after auto-restart)
    // complete on its first event without moving the count.
    assign reach_tc  = (count_inc >= {1'b0, tc_q});
    // Guards the increment so the count never passes the terminal value.
    assign below_tc  = (count_q < tc_q);

    // Next-state, capture and counter control; abort outranks everything
    // in the active states.
    always_comb begin
        state_d = state_q;
        tc_d    = tc_q;
        mode_d  = mode_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    tc_d    = tc;
                    mode_d  = mode;
                    cnt_clr = 1'b1;
                    state_d = (tc == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (x) begin
                    cnt_en = below_tc;
                    if (reach_tc) begin
                        state_d = ST_DONE;
                    end
                end else if (mode_q[MODE_CONSEC]) begin
                    cnt_clr = 1'b1;
                end
            end
            ST_DONE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (mode_q[MODE_AUTO]) begin
                    state_d = ST_RUN;
                    cnt_clr = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control registers; done is registered from the next state so it
    // coincides exactly with state = DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            tc_q    <= '0;
            mode_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tc_q    <= tc_d;
            mode_q  <= mode_d;
            done_q  <= (state_d == ST_DONE);
        end
    end

    sat_counter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .q     (count_q)
    );

    assign count = count_q;
    assign done  = done_q;
    assign busy  = (state_q != ST_IDLE);
    assign state = state_q;

endmodule : event_count_ctrl

// File: tb/tb_event_count_ctrl.sv
// Bench for event_count_ctrl (WIDTH = 4): a table of per-cycle vectors plus
// hand-written sequences for reset and saturation corners, checked through
// an expected-result queue.
module tb_event_count_ctrl;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         abort;
    logic         x;
    logic [W-1:0] tc;
    logic [1:0]   mode;
    logic [W-1:0] count;
    logic         done;
    logic         busy;
    logic [1:0]   state;

    event_count_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .abort (abort),
        .x     (x),
        .tc    (tc),
        .mode  (mode),
        .count (count),
        .done  (done),
        .busy  (busy),
        .state (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         start;
        logic         abort;
        logic         x;
        logic [W-1:0] tc;
        logic [1:0]   mode;
        logic [W-1:0] ecount;
        logic [1:0]   estate;
        logic         edone;
    } vec_t;

    typedef struct {
        logic [W-1:0] count;
        logic [1:0]   state;
        logic         done;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    int checks = 0;
    int passed = 0;

    function automatic vec_t v(input logic s, input logic a, input logic xi,
                               input int t, input int m,
                               input int ec, input int es, input logic ed);
        vec_t r;
        r.start  = s;
        r.abort  = a;
        r.x      = xi;
        r.tc     = W'(t);
        r.mode   = 2'(m);
        r.ecount = W'(ec);
        r.estate = 2'(es);
        r.edone  = ed;
        return r;
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act == req) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic check_outputs(input string name, input exp_t e);
        check({name, ".count"}, int'(count), int'(e.count));
        check({name, ".state"}, int'(state), int'(e.state));
        check({name, ".done"},  int'(done),  int'(e.done));
        check({name, ".busy"},  int'(busy),  int'(e.state != 2'd0));
    endtask

    // Drive one cycle of inputs, queue its expected result, then compare
    // just after the clock edge that consumes it.
    task automatic apply(input string name, input vec_t vi);
        exp_t e;
        exp_t got;
        start = vi.start;
        abort = vi.abort;
        x     = vi.x;
        tc    = vi.tc;
        mode  = vi.mode;
        e.count = vi.ecount;
        e.state = vi.estate;
        e.done  = vi.edone;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check({name, ".scoreboard_empty"}, 0, 1);
        end else begin
            got = sb.pop_front();
            check_outputs(name, got);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t rs;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        x     = 1'b0;
        tc    = '0;
        mode  = '0;

        // start abort x tc mode | count state done
        // Cumulative one-shot, tc=3; tc/mode changed after capture.
        tbl.push_back(v(1,0,0, 3,0, 0,1,0));
        tbl.push_back(v(0,0,1, 7,3, 1,1,0));
        tbl.push_back(v(0,0,0, 7,3, 1,1,0));
        tbl.push_back(v(0,0,1, 7,3, 2,1,0));
        tbl.push_back(v(0,0,1, 7,3, 3,2,1));
        tbl.push_back(v(0,0,1, 7,3, 3,0,0));
        tbl.push_back(v(0,0,1, 7,3, 3,0,0));
        // Consecutive one-shot, tc=3; start mid-run is ignored.
        tbl.push_back(v(1,0,0, 3,1, 0,1,0));
        tbl.push_back(v(0,0,1, 3,1, 1,1,0));
        tbl.push_back(v(0,0,1, 3,1, 2,1,0));
        tbl.push_back(v(0,0,0, 3,1, 0,1,0));
        tbl.push_back(v(1,0,1, 0,0, 1,1,0));
        tbl.push_back(v(0,0,1, 3,1, 2,1,0));
        tbl.push_back(v(0,0,1, 3,1, 3,2,1));
        tbl.push_back(v(0,0,0, 3,1, 3,0,0));
        // Auto-restart, tc=2, x held high, then abort.
        tbl.push_back(v(1,0,1, 2,2, 0,1,0));
        tbl.push_back(v(0,0,1, 2,2, 1,1,0));
        tbl.push_back(v(0,0,1, 2,2, 2,2,1));
        tbl.push_back(v(0,0,1, 2,2, 0,1,0));
        tbl.push_back(v(0,0,1, 2,2, 1,1,0));
        tbl.push_back(v(0,0,1, 2,2, 2,2,1));
        tbl.push_back(v(0,0,1, 2,2, 0,1,0));
        tbl.push_back(v(0,0,1, 2,2, 1,1,0));
        tbl.push_back(v(0,1,1, 2,2, 1,0,0));
        tbl.push_back(v(0,0,1, 2,2, 1,0,0));
        tbl.push_back(v(0,0,1, 2,2, 1,0,0));
        // Terminal count of zero completes immediately.
        tbl.push_back(v(1,0,0, 0,0, 0,2,1));
        tbl.push_back(v(0,0,0, 0,0, 0,0,0));
        // Abort beats an increment that would reach tc.
        tbl.push_back(v(1,0,0, 3,0, 0,1,0));
        tbl.push_back(v(0,0,1, 3,0, 1,1,0));
        tbl.push_back(v(0,0,1, 3,0, 2,1,0));
        tbl.push_back(v(0,1,1, 3,0, 2,0,0));
        tbl.push_back(v(0,0,1, 3,0, 2,0,0));
        // Abort in DONE beats auto-restart.
        tbl.push_back(v(1,0,0, 1,2, 0,1,0));
        tbl.push_back(v(0,0,1, 1,2, 1,2,1));
        tbl.push_back(v(0,1,1, 1,2, 1,0,0));
        tbl.push_back(v(0,0,0, 1,2, 1,0,0));

        // Reset state, checked while reset is held.
        #12;
        rs.count = '0; rs.state = 2'd0; rs.done = 1'b0;
        check_outputs("reset", rs);
        #5 rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (tbl[i]) begin
            apply($sformatf("vec%0d", i), tbl[i]);
        end

        // Full-range run, tc=15: count climbs to the maximum without wrapping.
        apply("max_start", v(1,0,0, 15,0, 0,1,0));
        for (int i = 1; i <= 15; i++) begin
            apply($sformatf("max%0d", i), v(0,0,1, 0,0, i, (i == 15) ? 2 : 1, i == 15));
        end
        apply("max_idle", v(0,0,1, 0,0, 15,0,0));

        // Asynchronous reset mid-run at count=5, seen before the next edge.
        apply("mid_start", v(1,0,0, 9,0, 0,1,0));
        for (int i = 1; i <= 5; i++) begin
            apply($sformatf("mid%0d", i), v(0,0,1, 9,0, i,1,0));
        end
        #2 rst_n = 1'b0;
        #1;
        check_outputs("mid_reset", rs);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        // First start after reset is taken on the first edge that sees it.
        apply("post_reset_start", v(1,0,1, 2,0, 0,1,0));
        apply("post_reset_x1",    v(0,0,1, 2,0, 1,1,0));
        apply("post_reset_x2",    v(0,0,1, 2,0, 2,2,1));
        apply("post_reset_idle",  v(0,0,0, 2,0, 2,0,0));

        check("scoreboard_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule : tb_event_count_ctrl
